// File: rtl/cdm16_irq_pkg.sv
// Shared constants for the cdm16 interrupt controller: register offsets and
// the source-count limit used by the elaboration checks.
package cdm16_irq_pkg;

  // Byte offsets of the registers from BASE_ADDR
  localparam logic [3:0] REG_PEND   = 4'h0;
  localparam logic [3:0] REG_MASK   = 4'h2;
  localparam logic [3:0] REG_MODE   = 4'h4;
  localparam logic [3:0] REG_ACTIVE = 4'h6;
  localparam logic [3:0] REG_SWSET  = 4'h8;

  // Registers are 16 bits wide and int_vec offsets use a 4-bit index
  function automatic int max_nsrc();
    return 16;
  endfunction

endpackage

// File: rtl/cdm16_irq_ctrl_if.sv
// cdm16 memory-bus signals seen by a memory-mapped responder.
interface cdm16_irq_ctrl_if;
  logic [15:0] bus_address;
  logic        bus_mem;
  logic        bus_data;
  logic        bus_read;
  logic        bus_word;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_rdata_en;

  modport master (
    output bus_address, bus_mem, bus_data, bus_read, bus_word, bus_wdata,
    input  bus_rdata, bus_rdata_en
  );

  modport slave (
    input  bus_address, bus_mem, bus_data, bus_read, bus_word, bus_wdata,
    output bus_rdata, bus_rdata_en
  );
endinterface

// File: rtl/cdm16_irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module cdm16_irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [3:0]   idx
);

  // Scan from the top so the lowest set bit is the last assignment
  always_comb begin
    any = |req;
    idx = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/cdm16_irq_ctrl.sv
// cdm16 interrupt controller: synchronises external requests, latches them
// (edge) or follows them (level), masks, prioritises and presents a vector to
// the CPU. Also a memory-mapped register block on the cdm16 data bus.
module cdm16_irq_ctrl
  import cdm16_irq_pkg::*;
#(
  parameter int          NSRC      = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter logic [5:0]  VEC_BASE  = 6'd16
) (
  input  logic            input_clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  cdm16_irq_ctrl_if.slave bus,
  output logic            irq,
  output logic [5:0]      int_vec,
  input  logic            iack
);

  generate
    if (NSRC < 1 || NSRC > max_nsrc()) begin : g_bad_nsrc
      $error("cdm16_irq_ctrl: NSRC must be 1..16");
    end
    if (BASE_ADDR[3:0] != 4'h0) begin : g_bad_base
      $error("cdm16_irq_ctrl: BASE_ADDR must be 16-byte aligned");
    end
    if (int'(VEC_BASE) + NSRC - 1 > 63) begin : g_bad_vec
      $error("cdm16_irq_ctrl: VEC_BASE+NSRC-1 exceeds 63");
    end
  endgenerate

  // Bits at or above NSRC are forced to zero everywhere
  localparam logic [15:0] VALID = 16'((32'd1 << NSRC) - 32'd1);

  logic [15:0] sync0_q, sync1_q, s_q;
  logic [15:0] pend_q, mask_q, mode_q;
  logic        iack_q;

  logic [15:0] pend_d, mask_d, mode_d;
  logic [15:0] src16, s, rise, pend_vis, req;
  logic [15:0] wdat, wmsk, wbits, w1c, sw, iack_clr, word_rd;
  logic [2:0]  ridx;
  logic        hit, wr, wr_pend, wr_mask, wr_mode, wr_swset, iack_pulse;
  logic        enc_any;
  logic [3:0]  enc_idx;
  logic [15:0] active;

  assign src16 = 16'(src_irq);
  assign s     = sync1_q;
  assign rise  = s & ~s_q;

  // Edge bits come from the latch; level bits follow the synchronised line
  assign pend_vis = (pend_q & mode_q) | (s & ~mode_q);
  assign req      = pend_vis & mask_q;

  cdm16_irq_prio_enc #(.N(NSRC)) u_prio (
    .req (req[NSRC-1:0]),
    .any (enc_any),
    .idx (enc_idx)
  );

  assign irq     = enc_any;
  assign int_vec = enc_any ? (VEC_BASE + {2'b00, enc_idx}) : 6'd0;
  assign active  = {irq, 9'b0, int_vec};

  // Bus decode
  assign hit      = bus.bus_mem & bus.bus_data &
                    (bus.bus_address[15:4] == BASE_ADDR[15:4]);
  assign wr       = hit & ~bus.bus_read;
  assign ridx     = bus.bus_address[3:1];
  assign wr_pend  = wr & (ridx == REG_PEND[3:1]);
  assign wr_mask  = wr & (ridx == REG_MASK[3:1]);
  assign wr_mode  = wr & (ridx == REG_MODE[3:1]);
  assign wr_swset = wr & (ridx == REG_SWSET[3:1]);

  // Lane write data and byte mask; byte writes always carry data in wdata[7:0]
  always_comb begin
    if (bus.bus_word) begin
      wdat = bus.bus_wdata;
      wmsk = 16'hFFFF;
    end else if (bus.bus_address[0]) begin
      wdat = {bus.bus_wdata[7:0], 8'h00};
      wmsk = 16'hFF00;
    end else begin
      wdat = {8'h00, bus.bus_wdata[7:0]};
      wmsk = 16'h00FF;
    end
  end

  assign wbits = wdat & wmsk;

  // Register read mux, byte reads returned in the low byte
  always_comb begin
    word_rd = 16'h0000;
    case (ridx)
      REG_PEND[3:1]:   word_rd = pend_vis;
      REG_MASK[3:1]:   word_rd = mask_q;
      REG_MODE[3:1]:   word_rd = mode_q;
      REG_ACTIVE[3:1]: word_rd = active;
      default:         word_rd = 16'h0000;
    endcase
    if (!hit)                  bus.bus_rdata = 16'h0000;
    else if (bus.bus_word)     bus.bus_rdata = word_rd;
    else if (bus.bus_address[0]) bus.bus_rdata = {8'h00, word_rd[15:8]};
    else                       bus.bus_rdata = {8'h00, word_rd[7:0]};
  end

  assign bus.bus_rdata_en = hit & bus.bus_read;

  // One clear per rising IAck, aimed at whichever source is presented now
  assign iack_pulse = iack & ~iack_q;
  assign iack_clr   = (iack_pulse & enc_any) ? (16'd1 << enc_idx) : 16'h0000;
  assign w1c        = wr_pend  ? wbits : 16'h0000;
  assign sw         = wr_swset ? wbits : 16'h0000;

  // Next state of the software-visible registers
  always_comb begin
    mask_d = wr_mask ? (((mask_q & ~wmsk) | wbits) & VALID) : mask_q;
    mode_d = wr_mode ? (((mode_q & ~wmsk) | wbits) & VALID) : mode_q;
    // Latch only for bits that are edge both now and next; a level->edge
    // switch therefore starts from a clear latch. Sets are OR'd last so they
    // win over W1C and IAck in the same edge.
    pend_d = VALID & mode_q & mode_d &
             ((pend_q & ~w1c & ~iack_clr) | rise | sw);
  end

  // All state: synchroniser, edge history, registers, IAck history
  always_ff @(posedge input_clock) begin
    if (reset) begin
      sync0_q <= '0;
      sync1_q <= '0;
      s_q     <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      iack_q  <= 1'b0;
    end else begin
      sync0_q <= src16;
      sync1_q <= sync0_q;
      s_q     <= sync1_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      iack_q  <= iack;
    end
  end

endmodule

// File: tb/tb_cdm16_irq_ctrl.sv
// Directed bench for cdm16_irq_ctrl. Main instance uses NSRC=16 so the high
// MASK byte is writable; a second NSRC=8 instance checks ignored upper bits.
module tb_cdm16_irq_ctrl;

  logic        input_clock = 1'b0;
  logic        reset;
  logic [15:0] src;
  logic        iack;
  logic        irq, irq8;
  logic [5:0]  int_vec, vec8;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 input_clock = ~input_clock;

  cdm16_irq_ctrl_if bus();
  cdm16_irq_ctrl_if bus8();

  cdm16_irq_ctrl #(.NSRC(16), .BASE_ADDR(16'hFF00), .VEC_BASE(6'd16)) dut (
    .input_clock (input_clock),
    .reset       (reset),
    .src_irq     (src),
    .bus         (bus),
    .irq         (irq),
    .int_vec     (int_vec),
    .iack        (iack)
  );

  cdm16_irq_ctrl #(.NSRC(8), .BASE_ADDR(16'hFF00), .VEC_BASE(6'd16)) dut8 (
    .input_clock (input_clock),
    .reset       (reset),
    .src_irq     (8'h00),
    .bus         (bus8),
    .irq         (irq8),
    .int_vec     (vec8),
    .iack        (1'b0)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge input_clock);
    #1;
  endtask

  task automatic bus_idle();
    bus.bus_address = 16'h0000; bus.bus_mem = 1'b0; bus.bus_data = 1'b0;
    bus.bus_read = 1'b0; bus.bus_word = 1'b0; bus.bus_wdata = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic w);
    bus.bus_address = a; bus.bus_mem = 1'b1; bus.bus_data = 1'b1;
    bus.bus_read = 1'b0; bus.bus_word = w; bus.bus_wdata = d;
    tick();
    bus_idle();
  endtask

  task automatic rchk(input string tag, input logic [15:0] a, input logic w,
                      input logic [15:0] exp);
    bus.bus_address = a; bus.bus_mem = 1'b1; bus.bus_data = 1'b1;
    bus.bus_read = 1'b1; bus.bus_word = w;
    #1;
    check(tag, bus.bus_rdata, exp);
    bus_idle();
  endtask

  initial begin
    reset = 1'b1; src = 16'h0000; iack = 1'b0;
    bus_idle();
    bus8.bus_address = 16'h0000; bus8.bus_mem = 1'b0; bus8.bus_data = 1'b0;
    bus8.bus_read = 1'b0; bus8.bus_word = 1'b0; bus8.bus_wdata = 16'h0000;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_irq", 16'(irq), 16'h0000);
    check("rst_vec", 16'(int_vec), 16'h0000);
    check("rst_rden", 16'(bus.bus_rdata_en), 16'h0000);
    rchk("rst_pend", 16'hFF00, 1'b1, 16'h0000);
    rchk("rst_mask", 16'hFF02, 1'b1, 16'h0000);

    // Edge source 3 latched while masked; then unmask
    wr(16'hFF04, 16'h00FF, 1'b1);
    src = 16'h0008;
    tick(); tick();
    src = 16'h0000;
    rchk("t1_pend_2edges", 16'hFF00, 1'b1, 16'h0000);
    tick();
    rchk("t1_pend", 16'hFF00, 1'b1, 16'h0008);
    check("t1_irq_masked", 16'(irq), 16'h0000);
    wr(16'hFF02, 16'h00FF, 1'b1);
    check("t1_irq", 16'(irq), 16'h0001);
    check("t1_vec", 16'(int_vec), 16'd19);

    // Priority and IAck
    wr(16'hFF00, 16'hFFFF, 1'b1);
    src = 16'h0024;
    tick(); tick(); tick();
    check("t2_vec18", 16'(int_vec), 16'd18);
    iack = 1'b1; tick(); iack = 1'b0;
    check("t2_vec21", 16'(int_vec), 16'd21);
    tick();
    wr(16'hFF08, 16'h0004, 1'b1);
    rchk("t2_pend_sw", 16'hFF00, 1'b1, 16'h0024);
    iack = 1'b1; tick(); tick(); tick(); tick(); iack = 1'b0;
    rchk("t2_hold_pend", 16'hFF00, 1'b1, 16'h0020);
    check("t2_hold_vec", 16'(int_vec), 16'd21);
    tick();
    iack = 1'b1; tick(); iack = 1'b0;
    check("t2_irq_off", 16'(irq), 16'h0000);
    src = 16'h0000;
    tick(); tick(); tick();

    // Level source 1
    wr(16'hFF04, 16'h00FD, 1'b1);
    src = 16'h0002;
    tick(); tick();
    rchk("t3_lvl_on", 16'hFF00, 1'b1, 16'h0002);
    wr(16'hFF00, 16'h0002, 1'b1);
    rchk("t3_w1c_none", 16'hFF00, 1'b1, 16'h0002);
    check("t3_vec17", 16'(int_vec), 16'd17);
    src = 16'h0000;
    tick();
    rchk("t3_lvl_1edge", 16'hFF00, 1'b1, 16'h0002);
    tick();
    rchk("t3_lvl_off", 16'hFF00, 1'b1, 16'h0000);

    // Byte access to MASK high byte
    wr(16'hFF03, 16'h00A5, 1'b0);
    rchk("t4_mask_word", 16'hFF02, 1'b1, 16'hA5FF);
    rchk("t4_mask_hi", 16'hFF03, 1'b0, 16'h00A5);
    rchk("t4_mask_lo", 16'hFF02, 1'b0, 16'h00FF);

    // Set wins over W1C, SWSET, ACTIVE
    wr(16'hFF04, 16'h00FF, 1'b1);
    src = 16'h0001;
    tick(); tick();
    wr(16'hFF00, 16'h0001, 1'b1);
    rchk("t5_set_wins", 16'hFF00, 1'b1, 16'h0001);
    wr(16'hFF00, 16'h0001, 1'b1);
    rchk("t5_w1c", 16'hFF00, 1'b1, 16'h0000);
    src = 16'h0000;
    wr(16'hFF08, 16'h0010, 1'b1);
    rchk("t5_swset", 16'hFF00, 1'b1, 16'h0010);
    rchk("t5_swset_rd", 16'hFF08, 1'b1, 16'h0000);
    rchk("t5_active", 16'hFF06, 1'b1, 16'h8014);
    tick();
    rchk("t5_unmapped", 16'hFF0A, 1'b1, 16'h0000);
    bus.bus_address = 16'hFF02; bus.bus_mem = 1'b1; bus.bus_data = 1'b0;
    bus.bus_read = 1'b1; bus.bus_word = 1'b1;
    #1;
    check("t5_nohit_rdata", bus.bus_rdata, 16'h0000);
    check("t5_nohit_rden", 16'(bus.bus_rdata_en), 16'h0000);
    bus.bus_data = 1'b1;
    #1;
    check("t5_hit_rden", 16'(bus.bus_rdata_en), 16'h0001);
    bus_idle();

    // Reset during a write with irq active
    check("t6_pre_irq", 16'(irq), 16'h0001);
    bus.bus_address = 16'hFF02; bus.bus_mem = 1'b1; bus.bus_data = 1'b1;
    bus.bus_read = 1'b0; bus.bus_word = 1'b1; bus.bus_wdata = 16'h1234;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_idle();
    check("t6_irq", 16'(irq), 16'h0000);
    check("t6_vec", 16'(int_vec), 16'h0000);
    rchk("t6_pend", 16'hFF00, 1'b1, 16'h0000);
    rchk("t6_mask", 16'hFF02, 1'b1, 16'h0000);
    rchk("t6_mode", 16'hFF04, 1'b1, 16'h0000);

    // NSRC=8: upper bits ignore writes
    bus8.bus_address = 16'hFF02; bus8.bus_mem = 1'b1; bus8.bus_data = 1'b1;
    bus8.bus_read = 1'b0; bus8.bus_word = 1'b1; bus8.bus_wdata = 16'hFFFF;
    tick();
    bus8.bus_read = 1'b1;
    #1;
    check("n8_mask", bus8.bus_rdata, 16'h00FF);
    check("n8_irq", 16'(irq8), 16'h0000);
    bus8.bus_mem = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
